// File: rtl/ray_dispatcher_pkg.sv
// Shared fixed-point types and helpers for the ray pipeline, plus the
// dispatcher state encoding.
package ray_dispatcher_pkg;

  localparam int FP_W    = 32;
  localparam int FP_FRAC = 16;

  typedef logic signed [FP_W-1:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  localparam fp FP_ONE = 32'sh0001_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OFFER   = 2'd2,
    ST_DONE    = 2'd3
  } disp_state_t;

  // Elaboration-time only: turns a real constant into Q16.16.
  function automatic fp fp_from_real(input real r);
    return fp'($rtoi(r * 65536.0));
  endfunction

  function automatic vec3 make_vec3(input fp x, input fp y, input fp z);
    vec3 v;
    v.x = x;
    v.y = y;
    v.z = z;
    return v;
  endfunction

  function automatic fp fp_mul(input fp a, input fp b);
    logic signed [2*FP_W-1:0] p;
    p = (2*FP_W)'(a) * (2*FP_W)'(b);
    return p[FP_FRAC +: FP_W];
  endfunction

  // Small signed integer times fp; result truncated to fp width.
  function automatic fp fp_scale_int(input logic signed [15:0] k, input fp f);
    logic signed [FP_W+15:0] p;
    p = (FP_W+16)'(k) * (FP_W+16)'(f);
    return p[FP_W-1:0];
  endfunction

endpackage

// File: rtl/ray_dispatcher_pixel_dir_calc.sv
// Pinhole projection: maps a raster position to an unnormalised primary ray
// direction (x_off, y_off, 1.0). Purely combinational.
module pixel_dir_calc
  import ray_dispatcher_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 400,
  parameter int DISPLAY_HEIGHT = 300,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 9,
  parameter fp  PIX_STEP       = fp_from_real(1.0 / 256.0)
) (
  input  logic [H_BITS-1:0] h_in,
  input  logic [V_BITS-1:0] v_in,
  output vec3               dir_out
);

  localparam logic signed [H_BITS:0] H_MID = (H_BITS+1)'(DISPLAY_WIDTH / 2);
  localparam logic signed [V_BITS:0] V_MID = (V_BITS+1)'(DISPLAY_HEIGHT / 2);

  logic signed [H_BITS:0] h_rel;
  logic signed [V_BITS:0] v_rel;

  // Screen y grows downward, so the vertical offset is mirrored.
  always_comb begin
    h_rel   = $signed({1'b0, h_in}) - H_MID;
    v_rel   = V_MID - $signed({1'b0, v_in});
    dir_out = make_vec3(fp_scale_int(16'(h_rel), PIX_STEP),
                        fp_scale_int(16'(v_rel), PIX_STEP),
                        FP_ONE);
  end

endmodule

// File: rtl/ray_dispatcher.sv
// Walks the raster once per start pulse and offers one primary ray per pixel
// to ray_unit over a valid/ready link.
module ray_dispatcher
  import ray_dispatcher_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 400,
  parameter int DISPLAY_HEIGHT = 300,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 9,
  parameter fp  PIX_STEP       = fp_from_real(1.0 / 256.0)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  vec3               camera_pos_in,
  input  logic              ready_in,
  output logic              valid_out,
  output vec3               ray_origin_out,
  output vec3               ray_direction_out,
  output logic [H_BITS-1:0] hcount_out,
  output logic [V_BITS-1:0] vcount_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output disp_state_t       state_dbg_out
);

  localparam logic [H_BITS-1:0] H_LAST = H_BITS'(DISPLAY_WIDTH - 1);
  localparam logic [V_BITS-1:0] V_LAST = V_BITS'(DISPLAY_HEIGHT - 1);

  // Handshake: a ray transfers on a clock edge where valid_out && ready_in.
  // Once valid_out rises, the payload holds until that edge; ready_in is
  // ignored whenever valid_out is low.

  disp_state_t       state_q, state_d;
  logic [H_BITS-1:0] h_q, h_d;
  logic [V_BITS-1:0] v_q, v_d;
  vec3               origin_q, origin_d;
  vec3               dir_q, dir_d;
  vec3               pix_dir;
  logic              last_pix;

  pixel_dir_calc #(
    .DISPLAY_WIDTH (DISPLAY_WIDTH),
    .DISPLAY_HEIGHT(DISPLAY_HEIGHT),
    .H_BITS        (H_BITS),
    .V_BITS        (V_BITS),
    .PIX_STEP      (PIX_STEP)
  ) u_dir (
    .h_in   (h_q),
    .v_in   (v_q),
    .dir_out(pix_dir)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      h_q      <= '0;
      v_q      <= '0;
      origin_q <= '0;
      dir_q    <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      origin_q <= origin_d;
      dir_q    <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    origin_d = origin_q;
    dir_d    = dir_q;
    last_pix = (h_q == H_LAST) && (v_q == V_LAST);
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          origin_d = camera_pos_in;
          h_d      = '0;
          v_d      = '0;
          state_d  = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        dir_d   = pix_dir;
        state_d = ST_OFFER;
      end
      ST_OFFER: begin
        if (ready_in) begin
          if (last_pix) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COMPUTE;
            if (h_q == H_LAST) begin
              h_d = '0;
              v_d = v_q + V_BITS'(1);
            end else begin
              h_d = h_q + H_BITS'(1);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign valid_out         = (state_q == ST_OFFER);
  assign busy_out          = (state_q != ST_IDLE);
  assign frame_done_out    = (state_q == ST_DONE);
  assign ray_origin_out    = origin_q;
  assign ray_direction_out = dir_q;
  assign hcount_out        = h_q;
  assign vcount_out        = v_q;
  assign state_dbg_out     = state_q;

endmodule
